chunked_seq_adder: RTL and testbench
====================================

// Module: chunked_seq_adder
// PURPOSE
//  Multi-cycle, area-reduced 64-bit adder. Adds a + b + c_in one CHUNK-bit slice per cycle, using a
//  registered inter-slice carry. Sits in the same datapath slot as the 64-bit ripple-carry adder.
//  Upstream producers hand it operands over a valid/ready handshake. It returns sum/c_out over a
//  valid/ready handshake. Results are bit-identical to the combinational 64-bit adder.
// PARAMETERS
//  WIDTH   64   operand/sum width in bits
//  CHUNK   16   slice width added per cycle; WIDTH % CHUNK == 0 required (elaboration error otherwise)
//  NCHUNK       derived localparam = WIDTH/CHUNK (default 4)
// PORTS
//  clk        in   1      single clock; all state changes on posedge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      block can accept operands (high only in IDLE)
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  c_in       in   1      carry in
//  out_valid  out  1      sum/c_out valid
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  a + b + c_in, mod 2^WIDTH
//  c_out      out  1      carry out of bit WIDTH-1
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE, idx=0, carry=0, sum=0, c_out=0, out_valid=0. in_ready=1 from next cycle.
//  FSM IDLE -> ADD -> DONE -> IDLE:
//   IDLE: in_ready=1. On in_valid&&in_ready: capture a, b into operand regs; carry<=c_in; idx<=0; go to ADD.
//   ADD: {carry, sum[idx*CHUNK +: CHUNK]} <= a_r slice + b_r slice + carry; idx<=idx+1.
//     When idx==NCHUNK-1: c_out<=slice carry, go to DONE.
//   DONE: out_valid=1. sum/c_out are held stable until out_ready. On out_valid&&out_ready, go to IDLE.
//  Latency: operands accepted at edge T -> out_valid high after edge T+NCHUNK. Min issue interval NCHUNK+2.
//  in_ready is low in ADD/DONE. in_valid there is ignored; the producer must hold its beat.
//  Input pins a/b/c_in may change after acceptance without effect (captured copies are used).
//  Adding all-ones + all-ones + 1 wraps: sum = all-ones, c_out=1. No other saturation.
//  rst mid-ADD or mid-DONE aborts the op: no out_valid pulse; partial sum cleared to 0.
//  sum holds its last value in IDLE; it is only meaningful while out_valid=1.
// CONFIGURATION
//  Macro CHUNKED_ADDER_OVF_EN:
//   defined: adds output port ovf (1 bit, reset 0). Signed two's-complement overflow,
//     = carry into bit WIDTH-1 XOR c_out. Set on the last ADD cycle, valid with out_valid.
//   undefined: no ovf port and no related logic.
// STRUCTURE
//  Package adder_pkg: WIDTH_DEFAULT=64, CHUNK_DEFAULT=16, typedef enum {IDLE, ADD, DONE} add_state_t.
//  Sub-module chunk_rca #(CHUNK): combinational CHUNK-bit ripple-carry adder (full-adder chain).
//   Ports a, b, c_in, sum, c_out; it also exposes the carry into its MSB for ovf.
//  Top holds the FSM, idx counter, operand/sum regs and carry reg, and instantiates one chunk_rca.
// TESTING (scoreboard every result against a+b+c_in computed in the bench)
//  1. a=64'hFFFFFFFFFFFFFFFF, b=64'hFFFFFFFFFFFFFFFF, c_in=1 -> sum=64'hFFFFFFFFFFFFFFFF, c_out=1.
//     out_valid is first seen 4 cycles after the accept edge.
//  2. a=64'hA180C9BFC723279F, b=64'hA282AC73ED441906, c_in=0 -> sum=64'h44037633B46740A5, c_out=1.
//  3. Backpressure: hold out_ready=0 for 10 cycles in DONE.
//     -> out_valid stays 1, sum/c_out stay stable, in_ready stays 0; IDLE the cycle after out_ready=1.
//  4. Assert rst on the 2nd ADD cycle -> out_valid never pulses; sum=0; in_ready=1 the cycle after rst drops.
//  5. in_valid held high with 2 queued ops, out_ready=1.
//     -> 2nd op is accepted only in IDLE after the 1st handshake; both results match the scoreboard.
//  6. (CHUNKED_ADDER_OVF_EN) a=64'h7FFFFFFFFFFFFFFF, b=64'h1, c_in=0
//     -> sum=64'h8000000000000000, ovf=1, c_out=0.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared defaults and FSM state type for the chunked sequential adder.
package adder_pkg;
    localparam int WIDTH_DEFAULT = 64;
    localparam int CHUNK_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } add_state_t;
endpackage

// File: rtl/chunk_rca.sv
// Combinational CHUNK-bit ripple-carry adder built from a full-adder chain.
// The carry into the MSB is exposed only when CHUNKED_ADDER_OVF_EN is defined.
module chunk_rca #(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             c_in,
    output logic [CHUNK-1:0] sum,
    output logic             c_out
`ifdef CHUNKED_ADDER_OVF_EN
    ,
    output logic             c_msb
`endif
);
    logic [CHUNK:0] c;

    assign c[0] = c_in;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign c_out = c[CHUNK];
`ifdef CHUNKED_ADDER_OVF_EN
    assign c_msb = c[CHUNK-1];
`endif
endmodule

// File: rtl/chunked_seq_adder.sv
// Sequential WIDTH-bit adder, one CHUNK slice per cycle; result valid NCHUNK cycles after accept.
// Accepts only in IDLE, holds sum/c_out in DONE until out_ready. CHUNKED_ADDER_OVF_EN adds ovf.
module chunked_seq_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int CHUNK = CHUNK_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             busy
`ifdef CHUNKED_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("chunked_seq_adder: WIDTH must be a multiple of CHUNK");
    end

    add_state_t        state_q;
    logic [IDXW-1:0]   idx_q;
    logic [WIDTH-1:0]  a_q, b_q, sum_q;
    logic              carry_q, c_out_q, out_valid_q;

    logic [CHUNK-1:0]  slice_a_d, slice_b_d, slice_sum_d;
    logic              slice_cout_d;

    assign slice_a_d = a_q[idx_q*CHUNK +: CHUNK];
    assign slice_b_d = b_q[idx_q*CHUNK +: CHUNK];

`ifdef CHUNKED_ADDER_OVF_EN
    logic slice_cmsb_d;
    logic ovf_q;
`endif

    chunk_rca #(.CHUNK(CHUNK)) u_rca (
        .a     (slice_a_d),
        .b     (slice_b_d),
        .c_in  (carry_q),
        .sum   (slice_sum_d),
        .c_out (slice_cout_d)
`ifdef CHUNKED_ADDER_OVF_EN
        ,
        .c_msb (slice_cmsb_d)
`endif
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            c_out_q     <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef CHUNKED_ADDER_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= c_in;
                        idx_q   <= '0;
                        state_q <= ADD;
                    end
                end
                ADD: begin
                    sum_q[idx_q*CHUNK +: CHUNK] <= slice_sum_d;
                    carry_q <= slice_cout_d;
                    if (idx_q == LAST_IDX) begin
                        idx_q       <= '0;
                        c_out_q     <= slice_cout_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
`ifdef CHUNKED_ADDER_OVF_EN
                        // Signed overflow: carry into the sign bit disagrees with carry out of it.
                        ovf_q       <= slice_cmsb_d ^ slice_cout_d;
`endif
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign c_out     = c_out_q;
`ifdef CHUNKED_ADDER_OVF_EN
    assign ovf       = ovf_q;
`endif
endmodule

// File: tb/tb_chunked_seq_adder.sv
// Directed + randomized bench for chunked_seq_adder, scored against plain 65-bit arithmetic.
module tb_chunked_seq_adder;
    localparam int W = 64;
    localparam int NCH = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         c_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         c_out;
    logic         busy;
`ifdef CHUNKED_ADDER_OVF_EN
    logic         ovf;
`endif

    int n_cmp = 0;
    int n_err = 0;

    chunked_seq_adder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .busy      (busy)
`ifdef CHUNKED_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [64:0] ref_add(input logic [63:0] x, input logic [63:0] y, input logic ci);
        return {1'b0, x} + {1'b0, y} + {64'd0, ci};
    endfunction

`ifdef CHUNKED_ADDER_OVF_EN
    function automatic logic ref_ovf(input logic [63:0] x, input logic [63:0] y, input logic ci);
        logic [64:0] s;
        s = ref_add(x, y, ci);
        return (x[63] == y[63]) && (s[63] != x[63]);
    endfunction
`endif

    // One transaction: accept, scramble pins, time the result, apply `hold` cycles of backpressure.
    task automatic run_op(input string tag, input logic [63:0] xa, input logic [63:0] xb, input logic xc,
                          input logic [63:0] esum, input logic ecout, input int hold);
        int k;
        for (int i = 0; i < 20 && !in_ready; i++) tick();
        chk({tag, "_in_ready"}, 65'(in_ready), 65'd1);
        a = xa; b = xb; c_in = xc; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; c_in = 1'($urandom);
        k = 0;
        while (!out_valid && k < 20) begin
            chk({tag, "_rdy_low_add"}, 65'(in_ready), 65'd0);
            tick();
            k++;
        end
        chk({tag, "_latency"}, 65'(k), 65'(NCH));
        chk({tag, "_sum"}, {1'b0, sum}, {1'b0, esum});
        chk({tag, "_cout"}, 65'(c_out), 65'(ecout));
`ifdef CHUNKED_ADDER_OVF_EN
        chk({tag, "_ovf"}, 65'(ovf), 65'(ref_ovf(xa, xb, xc)));
`endif
        for (int h = 0; h < hold; h++) begin
            tick();
            chk({tag, "_hold_vld"}, 65'(out_valid), 65'd1);
            chk({tag, "_hold_sum"}, {ecout, sum}, {ecout, esum});
            chk({tag, "_hold_cout"}, 65'(c_out), 65'(ecout));
            chk({tag, "_hold_rdy"}, 65'(in_ready), 65'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_vld_drop"}, 65'(out_valid), 65'd0);
        chk({tag, "_idle"}, {63'd0, busy, in_ready}, 65'b01);
    endtask

    initial begin
        logic [63:0] ra, rb, qa[2], qb[2];
        logic        rc, qc[2];
        logic [64:0] e;
        int acc, done, last_acc;
        logic took;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; c_in = 1'b0;
        tick(); tick();
        chk("rst_out_valid", 65'(out_valid), 65'd0);
        chk("rst_sum", {1'b0, sum}, 65'd0);
        chk("rst_cout", 65'(c_out), 65'd0);
        chk("rst_busy", 65'(busy), 65'd0);
        rst = 1'b0;
        tick();
        chk("rst_in_ready", 65'(in_ready), 65'd1);

        run_op("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
               64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0);
        run_op("vec2", 64'hA180_C9BF_C723_279F, 64'hA282_AC73_ED44_1906, 1'b0,
               64'h4403_7633_B467_40A5, 1'b1, 0);

        ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; rc = 1'($urandom);
        e = ref_add(ra, rb, rc);
        run_op("bp10", ra, rb, rc, e[63:0], e[64], 10);

        // Abort during the second ADD cycle.
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; c_in = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_sum", {1'b0, sum}, 65'd0);
        chk("abort_vld", 65'(out_valid), 65'd0);
        chk("abort_in_ready", 65'(in_ready), 65'd1);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("abort_no_pulse", 65'(out_valid), 65'd0);
        end

        for (int t = 0; t < 8; t++) begin
            ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; rc = 1'($urandom);
            if (t == 0) rb = ~ra;
            e = ref_add(ra, rb, rc);
            run_op("rand", ra, rb, rc, e[63:0], e[64], int'($urandom_range(0, 3)));
        end

        // Two queued beats with in_valid held high and the consumer always ready.
        for (int i = 0; i < 2; i++) begin
            qa[i] = {$urandom, $urandom}; qb[i] = {$urandom, $urandom}; qc[i] = 1'($urandom);
        end
        a = qa[0]; b = qb[0]; c_in = qc[0]; in_valid = 1'b1; out_ready = 1'b1;
        acc = 0; done = 0; last_acc = -1;
        for (int cyc = 0; cyc < 60 && done < 2; cyc++) begin
            took = 1'b0;
            if (out_valid && out_ready) begin
                e = ref_add(qa[done], qb[done], qc[done]);
                chk("queue_sum", {c_out, sum}, e);
                done++;
            end
            if (in_valid && in_ready) begin
                chk("queue_order", 65'(acc), 65'(done));
                if (acc > 0) chk("queue_interval", 65'(cyc - last_acc), 65'(NCH + 2));
                last_acc = cyc;
                acc++;
                took = 1'b1;
            end
            tick();
            if (took) begin
                if (acc < 2) begin
                    a = qa[acc]; b = qb[acc]; c_in = qc[acc];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("queue_done", 65'(done), 65'd2);

`ifdef CHUNKED_ADDER_OVF_EN
        run_op("ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
